// File: rtl/mem_access_unit.sv
// Memory-side load/store unit for a word-wide, single-port, synchronous-read RAM.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemReq,
  input  logic                  MemW,
  input  logic [3:0]            ByteEn,
  input  logic [31:0]           Addr,
  input  logic [31:0]           WriteData,
  output logic [31:0]           ReadData,
  output logic                  LoadValid,
  output logic                  Stall,
  output logic                  AlignFault,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  // Handshake: the pipeline holds MemReq/MemW/ByteEn/Addr/WriteData stable
  // for every cycle Stall is high; the request is consumed in the first
  // cycle that Stall is low (IDLE for single-cycle ops, DONE otherwise).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic        is_byte;
  logic        is_half;
  logic        misaligned;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;
  logic [31:0] store_merge;
  logic        we_raw;
  logic        fault_set;
  logic        load_cap;
  logic        addr_unused;

  assign addr_unused = ^Addr[31:ADDR_WIDTH+2];
  assign ram_addr    = Addr[ADDR_WIDTH+1:2];

  // Any size code other than byte/halfword behaves as a full word.
  always_comb begin
    is_byte    = (ByteEn[2:0] == 3'b001);
    is_half    = (ByteEn[2:0] == 3'b011);
    misaligned = 1'b0;
    if (is_half)
      misaligned = Addr[0];
    else if (!is_byte)
      misaligned = (Addr[1:0] != 2'b00);
  end

  always_comb begin
    rd_byte = 8'h00;
    case (Addr[1:0])
      2'd0:    rd_byte = ram_rdata[7:0];
      2'd1:    rd_byte = ram_rdata[15:8];
      2'd2:    rd_byte = ram_rdata[23:16];
      default: rd_byte = ram_rdata[31:24];
    endcase
    rd_half = Addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];

    if (is_byte)
      load_ext = {{24{ByteEn[3] & rd_byte[7]}}, rd_byte};
    else if (is_half)
      load_ext = {{16{ByteEn[3] & rd_half[15]}}, rd_half};
    else
      load_ext = ram_rdata;
  end

  // Replace only the addressed lane of the word just read back.
  always_comb begin
    store_merge = ram_rdata;
    if (is_byte) begin
      case (Addr[1:0])
        2'd0:    store_merge[7:0]   = WriteData[7:0];
        2'd1:    store_merge[15:8]  = WriteData[7:0];
        2'd2:    store_merge[23:16] = WriteData[7:0];
        default: store_merge[31:24] = WriteData[7:0];
      endcase
    end else if (is_half) begin
      if (Addr[1])
        store_merge[31:16] = WriteData[15:0];
      else
        store_merge[15:0]  = WriteData[15:0];
    end else begin
      store_merge = WriteData;
    end
  end

  always_comb begin
    state_nxt = state;
    Stall     = 1'b0;
    we_raw    = 1'b0;
    ram_wdata = WriteData;
    fault_set = 1'b0;
    load_cap  = 1'b0;
    case (state)
      IDLE: begin
        if (MemReq) begin
          if (misaligned) begin
            fault_set = 1'b1;
          end else if (MemW && !is_byte && !is_half) begin
            we_raw = 1'b1;
          end else begin
            Stall     = 1'b1;
            state_nxt = RD;
          end
        end
      end
      RD: begin
        Stall     = 1'b1;
        state_nxt = DONE;
        if (MemW) begin
          we_raw    = 1'b1;
          ram_wdata = store_merge;
        end else begin
          load_cap = 1'b1;
        end
      end
      DONE: begin
        // Inputs still show the finished request; it must not be reissued.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Reset gates the strobe combinationally so an abandoned RMW never writes.
  assign ram_we = we_raw & reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      ReadData   <= 32'h0;
      LoadValid  <= 1'b0;
      AlignFault <= 1'b0;
    end else begin
      state      <= state_nxt;
      AlignFault <= fault_set;
      LoadValid  <= (fault_set & ~MemW) | load_cap;
      if (fault_set && !MemW)
        ReadData <= 32'h0;
      else if (load_cap)
        ReadData <= load_ext;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of loads/stores against a
// behavioural synchronous-read RAM, plus reset-abort and back-to-back sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReq;
  logic        MemW;
  logic [3:0]  ByteEn;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        LoadValid;
  logic        Stall;
  logic        AlignFault;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] hold_rd;

  typedef struct {
    string       name;
    logic        memw;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pre;
    int          exp_stall;
    int          exp_we;
    logic [31:0] exp_wdata;
    logic        exp_lv;
    logic        exp_af;
    logic [31:0] exp_rd;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vt [17];
  vec_t va;
  vec_t vb;

  mem_access_unit #(.ADDR_WIDTH(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReq     (MemReq),
    .MemW       (MemW),
    .ByteEn     (ByteEn),
    .Addr       (Addr),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .LoadValid  (LoadValid),
    .Stall      (Stall),
    .AlignFault (AlignFault),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // clock / RAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we)
      mem[pre_addr] <= pre_data;
    else if (ram_we)
      mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    MemReq   = 1'b0;
    pre_we   = 1'b1;
    pre_addr = addr[11:2];
    pre_data = data;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Issues one request and follows it to its result cycle; leaves inputs held
  // in DONE so a following call starts in the very next IDLE cycle.
  task automatic run_vec(input vec_t v);
    int          n_stall;
    int          we_cnt;
    logic [31:0] wd;
    logic [9:0]  wa;
    n_stall = 0;
    we_cnt  = 0;
    wd      = '0;
    wa      = '0;
    @(negedge clk);
    MemReq    = 1'b1;
    MemW      = v.memw;
    ByteEn    = v.be;
    Addr      = v.addr;
    WriteData = v.wdata;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (ram_we) begin
        we_cnt++;
        wd = ram_wdata;
        wa = ram_addr;
      end
      if (!Stall) break;
      n_stall++;
      @(negedge clk);
    end
    if (n_stall == 0) begin
      @(negedge clk);
      MemReq = 1'b0;
      #1;
      if (ram_we) we_cnt++;
    end
    chk({v.name, "/stall"}, 32'(n_stall), 32'(v.exp_stall));
    chk({v.name, "/we_cnt"}, 32'(we_cnt), 32'(v.exp_we));
    if (v.exp_we != 0) begin
      chk({v.name, "/wdata"}, wd, v.exp_wdata);
      chk({v.name, "/waddr"}, 32'(wa), 32'(v.addr[11:2]));
    end
    chk({v.name, "/lv"}, 32'(LoadValid), 32'(v.exp_lv));
    chk({v.name, "/af"}, 32'(AlignFault), 32'(v.exp_af));
    if (v.exp_lv) hold_rd = v.exp_rd;
    chk({v.name, "/rdata"}, ReadData, hold_rd);
    chk({v.name, "/mem"}, mem[v.addr[11:2]], v.exp_mem);
  endtask

  initial begin
    vt[0]  = '{"str_w",    1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0,        0, 1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        32'hDEADBEEF};
    vt[1]  = '{"strb",     1'b1, 4'h1, 32'h12, 32'h000000AB, 32'h11223344, 2, 1, 32'h11AB3344, 1'b0, 1'b0, 32'h0,        32'h11AB3344};
    vt[2]  = '{"ldrsb",    1'b0, 4'h9, 32'h12, 32'h0,        32'h80FF7F01, 2, 0, 32'h0,        1'b1, 1'b0, 32'hFFFFFFFF, 32'h80FF7F01};
    vt[3]  = '{"ldrb",     1'b0, 4'h1, 32'h11, 32'h0,        32'h80FF7F01, 2, 0, 32'h0,        1'b1, 1'b0, 32'h0000007F, 32'h80FF7F01};
    vt[4]  = '{"ldrsh",    1'b0, 4'hB, 32'h12, 32'h0,        32'h80FF7F01, 2, 0, 32'h0,        1'b1, 1'b0, 32'hFFFF80FF, 32'h80FF7F01};
    vt[5]  = '{"ldrh_mis", 1'b0, 4'h3, 32'h13, 32'h0,        32'h80FF7F01, 0, 0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h80FF7F01};
    vt[6]  = '{"str_mis",  1'b1, 4'h7, 32'h16, 32'hFFFFFFFF, 32'h12345678, 0, 0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h12345678};
    vt[7]  = '{"strh_hi",  1'b1, 4'h3, 32'h16, 32'h0000CAFE, 32'h12345678, 2, 1, 32'hCAFE5678, 1'b0, 1'b0, 32'h0,        32'hCAFE5678};
    vt[8]  = '{"ldr",      1'b0, 4'h7, 32'h14, 32'h0,        32'hA5A50F0F, 2, 0, 32'h0,        1'b1, 1'b0, 32'hA5A50F0F, 32'hA5A50F0F};
    vt[9]  = '{"ldrh_hi",  1'b0, 4'h3, 32'h16, 32'h0,        32'h80017FFF, 2, 0, 32'h0,        1'b1, 1'b0, 32'h00008001, 32'h80017FFF};
    vt[10] = '{"ldrsh_lo", 1'b0, 4'hB, 32'h14, 32'h0,        32'h80017FFF, 2, 0, 32'h0,        1'b1, 1'b0, 32'h00007FFF, 32'h80017FFF};
    vt[11] = '{"strb_b3",  1'b1, 4'h1, 32'h13, 32'hFFFFFF5A, 32'h0,        2, 1, 32'h5A000000, 1'b0, 1'b0, 32'h0,        32'h5A000000};
    vt[12] = '{"str_sz5",  1'b1, 4'h5, 32'h20, 32'h01020304, 32'h0,        0, 1, 32'h01020304, 1'b0, 1'b0, 32'h0,        32'h01020304};
    vt[13] = '{"ldr_sz0",  1'b0, 4'h0, 32'h24, 32'h0,        32'h89ABCDEF, 2, 0, 32'h0,        1'b1, 1'b0, 32'h89ABCDEF, 32'h89ABCDEF};
    vt[14] = '{"ldr_sz0m", 1'b0, 4'h0, 32'h26, 32'h0,        32'h89ABCDEF, 0, 0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h89ABCDEF};
    vt[15] = '{"ldrsb_b3", 1'b0, 4'h9, 32'h13, 32'h0,        32'h80000000, 2, 0, 32'h0,        1'b1, 1'b0, 32'hFFFFFF80, 32'h80000000};
    vt[16] = '{"strh_mis", 1'b1, 4'h3, 32'h11, 32'h00001234, 32'hAAAAAAAA, 0, 0, 32'h0,        1'b0, 1'b1, 32'h0,        32'hAAAAAAAA};

    // reset: strobe forced low even with a word store on the inputs
    reset     = 1'b0;
    MemReq    = 1'b1;
    MemW      = 1'b1;
    ByteEn    = 4'hF;
    Addr      = 32'h10;
    WriteData = 32'h12345678;
    hold_rd   = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst/ram_we", 32'(ram_we), 32'h0);
    chk("rst/rdata", ReadData, 32'h0);
    chk("rst/lv", 32'(LoadValid), 32'h0);
    chk("rst/af", 32'(AlignFault), 32'h0);
    chk("rst/state", 32'(dut.state), 32'h0);
    @(negedge clk);
    reset  = 1'b1;
    MemReq = 1'b0;
    #1;
    chk("idle/ram_we", 32'(ram_we), 32'h0);
    chk("idle/stall", 32'(Stall), 32'h0);

    for (int i = 0; i < 17; i++) begin
      preload(vt[i].addr, vt[i].pre);
      run_vec(vt[i]);
    end

    // reset during the RD cycle of a halfword RMW abandons the write
    preload(32'h10, 32'h11223344);
    @(negedge clk);
    MemReq    = 1'b1;
    MemW      = 1'b1;
    ByteEn    = 4'h3;
    Addr      = 32'h10;
    WriteData = 32'h0000BEEF;
    #1;
    chk("rstrd/issue_stall", 32'(Stall), 32'h1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstrd/ram_we", 32'(ram_we), 32'h0);
    @(negedge clk);
    reset  = 1'b1;
    MemReq = 1'b0;
    #1;
    hold_rd = 32'h0;
    chk("rstrd/state", 32'(dut.state), 32'h0);
    chk("rstrd/stall", 32'(Stall), 32'h0);
    chk("rstrd/rdata", ReadData, hold_rd);
    @(negedge clk);
    #1;
    chk("rstrd/mem", mem[4], 32'h11223344);

    // back-to-back load then byte store, no idle cycle between requests
    va = '{"b2b_ldr",  1'b0, 4'h7, 32'h10, 32'h0,        32'h55667788, 2, 0, 32'h0,        1'b1, 1'b0, 32'h55667788, 32'h55667788};
    vb = '{"b2b_strb", 1'b1, 4'h1, 32'h20, 32'h000000C3, 32'h0,        2, 1, 32'h000000C3, 1'b0, 1'b0, 32'h0,        32'h000000C3};
    preload(va.addr, va.pre);
    preload(vb.addr, vb.pre);
    run_vec(va);
    run_vec(vb);
    @(negedge clk);
    MemReq = 1'b0;
    #1;
    chk("b2b/end_stall", 32'(Stall), 32'h0);
    chk("b2b/end_state", 32'(dut.state), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side counterpart of the instruction decoder's load/store controls in the five-stage pipeline.
- Consumes MemW, MemtoReg and the 4-bit ByteEn code from the MEM stage, and drives a 32-bit word-wide, single-port, synchronous-read data RAM that has no byte-write lanes.
- Sub-word stores run as read-modify-write sequences. Loads extract the addressed byte/halfword and zero- or sign-extend it.
- Stall is asserted upward to freeze the pipeline while a sequence runs.

Parameters:
ADDR_WIDTH, 10, number of word-address bits presented to the RAM (RAM depth = 2**ADDR_WIDTH words)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
MemReq  input  1  valid memory operation in MEM stage (MemW | MemtoReg)
MemW  input  1  1 = store, 0 = load
ByteEn  input  4  [2:0] size: 001 byte, 011 halfword, 111 word; [3] sign-extend (loads only)
Addr  input  32  byte address from ALU
WriteData  input  32  store data, right-aligned
ReadData  output  32  extended load result
LoadValid  output  1  ReadData valid this cycle
Stall  output  1  hold pipeline (request inputs must stay stable while high)
AlignFault  output  1  one-cycle pulse on a misaligned access
ram_addr  output  ADDR_WIDTH  word address = Addr[ADDR_WIDTH+1:2]
ram_we  output  1  RAM write strobe
ram_wdata  output  32  RAM write data
ram_rdata  input  32  RAM read data, valid one cycle after address

Behaviour:
- Lane mapping is little-endian: byte k = bits [8k+7:8k], k = Addr[1:0]. Halfword h = bits [16h+15:16h], h = Addr[1].
- Size codes other than 001/011/111 are treated as word.
- States: IDLE, RD, DONE. Reset value for all state is IDLE.
- Registered outputs reset to ReadData=0, LoadValid=0, AlignFault=0.
- ram_we is combinational and forced 0 whenever reset is low, including a reset asserted while in RD.
- Misalignment check in IDLE with MemReq:
  - Halfword with Addr[0]=1, or word with Addr[1:0]!=0, is a misaligned access.
  - Response: no RAM write; AlignFault=1 next cycle; for a load, ReadData=0 and LoadValid=1 next cycle.
  - Stall=0; state stays IDLE.
- Word store, IDLE: ram_we=1, ram_wdata=WriteData, Stall=0; single cycle; state stays IDLE.
- Load or sub-word store, IDLE: drive ram_addr, Stall=1, go to RD.
- RD, load:
  - Extract lane from ram_rdata; zero-extend, or sign-extend if ByteEn[3]=1.
  - Register the result into ReadData; Stall=1; go to DONE.
- RD, sub-word store:
  - ram_wdata = ram_rdata with the addressed lane replaced by WriteData[7:0] or [15:0].
  - ram_we=1, Stall=1; go to DONE.
- DONE:
  - Stall=0; LoadValid=1 for loads. ReadData holds its value until the next load completes.
  - Go to IDLE. The request still on the inputs in DONE is the completed one and is not restarted.
- Latency:
  - Word store: 0 stall cycles.
  - Load and sub-word store: Stall high for 2 cycles; result/commit visible in the third cycle.
- ram_addr is driven from Addr in every state; ram_we=0 in IDLE without a word store and in DONE.
- MemReq=0 in IDLE: all strobes 0, Stall=0.
- Reset low in any state: state returns to IDLE next edge; any in-flight RMW is abandoned with no write.

Test Plan:
1. Word store Addr=0x10, WriteData=0xDEADBEEF, ByteEn=1111 -> same cycle ram_we=1, ram_addr=4, ram_wdata=0xDEADBEEF; Stall=0.
2. Word 4 holds 0x11223344. STRB Addr=0x12, WriteData=0x000000AB, ByteEn=0001 -> Stall=1 for 2 cycles; RD cycle ram_we=1, ram_wdata=0x11AB3344; DONE Stall=0.
3. Word 4 holds 0x80FF7F01. LDRSB Addr=0x12 (ByteEn=1001) -> ReadData=0xFFFFFFFF. LDRB Addr=0x11 (0001) -> 0x0000007F. LDRSH Addr=0x12 (1011) -> 0xFFFF80FF, each with LoadValid=1 in DONE.
4. LDRH Addr=0x13 -> AlignFault=1 and LoadValid=1 next cycle, ReadData=0, no Stall. STR Addr=0x16 -> AlignFault=1, ram_we never asserted.
5. STRH Addr=0x10, reset driven low during the RD cycle -> ram_we=0 that cycle, word 4 unchanged, state IDLE and Stall=0 after the edge.
6. Back-to-back LDR 0x10, then STRB 0x20 -> the load completes in DONE, and the store's read starts the following IDLE cycle (no lost or duplicated operation).
